// File: rtl/seg_pipe_adder.sv
// Pipelined segmented ripple adder/subtractor: one SEG_BITS segment per stage, carry registered between stages.
// Optional signed saturation of the sum on overflow is enabled by defining SEG_PIPE_ADDER_SAT_EN.
module seg_pipe_adder #(
    parameter int NO_BITS  = 32,
    parameter int SEG_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NO_BITS-1:0] A,
    input  logic [NO_BITS-1:0] B,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NO_BITS:0]   out,
    output logic               ovf
);

    localparam int NUM_SEG = NO_BITS / SEG_BITS;

    if (NO_BITS % SEG_BITS != 0) begin : g_bad_width
        $error("seg_pipe_adder: NO_BITS must be a multiple of SEG_BITS");
    end

    // Stage-k inputs: operands still to be added sit in the low bits, finished sum segments
    // collect at the top of st_s and shift down one segment per stage.
    logic [NO_BITS-1:0] st_a [NUM_SEG];
    logic [NO_BITS-1:0] st_b [NUM_SEG];
    logic [NO_BITS-1:0] st_s [NUM_SEG];
    logic               st_c [NUM_SEG];
    logic               st_v [NUM_SEG];

    logic               advance;
    logic               out_valid_q;
    logic [NO_BITS:0]   out_q;
    logic               ovf_q;

    // The whole pipe moves or freezes as one, so a stalled result never gets overwritten.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    assign st_a[0] = A;
    assign st_b[0] = sub ? ~B : B;
    assign st_s[0] = '0;
    assign st_c[0] = cin ^ sub;
    assign st_v[0] = in_valid;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic [SEG_BITS:0]  seg_sum;
        logic [NO_BITS-1:0] sum_next;

        assign seg_sum  = {1'b0, st_a[k][SEG_BITS-1:0]}
                        + {1'b0, st_b[k][SEG_BITS-1:0]}
                        + (SEG_BITS+1)'(st_c[k]);
        assign sum_next = (st_s[k] >> SEG_BITS)
                        | (NO_BITS'(seg_sum[SEG_BITS-1:0]) << (NO_BITS - SEG_BITS));

        if (k < NUM_SEG - 1) begin : g_mid
            logic [NO_BITS-1:0] a_q;
            logic [NO_BITS-1:0] b_q;
            logic [NO_BITS-1:0] s_q;
            logic               c_q;
            logic               v_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= st_v[k];
                end
            end

            // NOTE: datapath registers carry no reset; only the valid bits decide what is real,
            // so clearing the wide operand/sum flops would cost reset fan-out for nothing.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= st_a[k] >> SEG_BITS;
                    b_q <= st_b[k] >> SEG_BITS;
                    s_q <= sum_next;
                    c_q <= seg_sum[SEG_BITS];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_s[k+1] = s_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
        end else begin : g_last
            logic               carry_into_msb;
            logic               seg_ovf;
            logic [NO_BITS-1:0] res;

            assign carry_into_msb = st_a[k][SEG_BITS-1] ^ st_b[k][SEG_BITS-1] ^ seg_sum[SEG_BITS-1];
            assign seg_ovf        = carry_into_msb ^ seg_sum[SEG_BITS];

`ifdef SEG_PIPE_ADDER_SAT_EN
            always_comb begin
                res = sum_next;
                if (seg_ovf) begin
                    res = st_a[k][SEG_BITS-1] ? {1'b1, {(NO_BITS-1){1'b0}}}
                                              : {1'b0, {(NO_BITS-1){1'b1}}};
                end
            end
`else
            assign res = sum_next;
`endif

            // Result data only loads with a real beat, so bubbles leave the last result in place.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_q       <= '0;
                    ovf_q       <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= st_v[k];
                    if (st_v[k]) begin
                        out_q <= {seg_sum[SEG_BITS], res};
                        ovf_q <= seg_ovf;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder at NO_BITS=16, SEG_BITS=4 (four stages).
// A negedge monitor pushes model results on acceptance and pops them on each output transfer.
module tb_seg_pipe_adder;

    localparam int NB = 16;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] a_in;
    logic [NB-1:0] b_in;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [NB:0]   out;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int stall_seen = 0;

    typedef struct packed {
        logic [NB:0] res;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [NB:0] res;
        logic        ovf;
        int          cyc;
    } obs_t;

    exp_t sb_q[$];
    obs_t got_q[$];

    seg_pipe_adder #(.NO_BITS(NB), .SEG_BITS(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                   input logic c, input logic s);
        logic [NB-1:0] be;
        logic [NB:0]   r;
        exp_t          e;
        be    = s ? ~b : b;
        r     = {1'b0, a} + {1'b0, be} + (NB+1)'(c ^ s);
        e.ovf = (a[NB-1] == be[NB-1]) && (r[NB-1] != a[NB-1]);
`ifdef SEG_PIPE_ADDER_SAT_EN
        if (e.ovf) r[NB-1:0] = a[NB-1] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
`endif
        e.res = r;
        return e;
    endfunction

    // Monitor: inputs change only just after posedge, so negedge sees settled handshakes.
    initial begin
        logic [NB:0] held_out;
        logic        held_ovf;
        logic        holding;
        exp_t        e;
        obs_t        o;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                holding = 1'b0;
            end else begin
                if (holding) begin
                    checks++;
                    if (out_valid !== 1'b1 || out !== held_out || ovf !== held_ovf) begin
                        errors++;
                        $display("FAIL hold_stable: out=%h ovf=%b valid=%b expected out=%h ovf=%b valid=1",
                                 out, ovf, out_valid, held_out, held_ovf);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b0) begin
                    stall_seen++;
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: in_ready=%b expected 0", in_ready);
                    end
                    holding  = 1'b1;
                    held_out = out;
                    held_ovf = ovf;
                end else begin
                    holding = 1'b0;
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    o.res = out;
                    o.ovf = ovf;
                    o.cyc = cyc_cnt;
                    got_q.push_back(o);
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: out=%h ovf=%b with nothing outstanding", out, ovf);
                    end else begin
                        e = sb_q.pop_front();
                        if (out !== e.res || ovf !== e.ovf) begin
                            errors++;
                            $display("FAIL scoreboard: out=%h ovf=%b expected out=%h ovf=%b",
                                     out, ovf, e.res, e.ovf);
                        end
                    end
                end
                if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(model(a_in, b_in, cin, sub));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [NB-1:0] a, input logic [NB-1:0] b,
                             input logic c, input logic s);
        a_in     = a;
        b_in     = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                cyc();
                in_valid = 1'b0;
                return;
            end
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready=%b expected 1 within 50 cycles", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input string name, input int n, input int budget);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            cyc();
            t++;
        end
        cyc();
        cyc();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d results expected %0d", name, got_q.size(), n);
        end
    endtask

    task automatic check_latency(input string name, input logic [NB:0] exp_out, input logic exp_ovf);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_early: out_valid=%b expected 0 at %0d edges after accept", name, out_valid, i + 1);
            end
            cyc();
        end
        checks++;
        if (out_valid !== 1'b1 || out !== exp_out || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_latency: valid=%b out=%h ovf=%b expected valid=1 out=%h ovf=%b",
                     name, out_valid, out, ovf, exp_out, exp_ovf);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        cyc();
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%h ovf=%b expected 0/0/0", out_valid, out, ovf);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
        end
        cyc();
    endtask

    task automatic test_basic_add();
        got_q.delete();
        send_beat(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        check_latency("basic", 17'h02233, 1'b0);
        wait_results("basic", 1, 20);
    endtask

    task automatic test_carry();
        got_q.delete();
        send_beat(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send_beat(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_results("carry", 2, 20);
        if (got_q.size() >= 2) begin
            checks++;
            if (got_q[0].res !== 17'h10000 || got_q[0].ovf !== 1'b0) begin
                errors++;
                $display("FAIL carry_wrap: out=%h ovf=%b expected 10000/0", got_q[0].res, got_q[0].ovf);
            end
            checks++;
            if (got_q[1].res !== 17'h0FFFE || got_q[1].ovf !== 1'b0) begin
                errors++;
                $display("FAIL sub_borrow: out=%h ovf=%b expected 0fffe/0", got_q[1].res, got_q[1].ovf);
            end
        end
    endtask

    task automatic test_overflow();
        logic [NB:0] exp_pos;
        logic [NB:0] exp_neg;
`ifdef SEG_PIPE_ADDER_SAT_EN
        exp_pos = 17'h07FFF;
        exp_neg = 17'h18000;
`else
        exp_pos = 17'h08000;
        exp_neg = 17'h17FFF;
`endif
        got_q.delete();
        send_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send_beat(16'h8000, 16'h0001, 1'b0, 1'b1);
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        wait_results("ovf", 3, 20);
        if (got_q.size() >= 3) begin
            checks++;
            if (got_q[0].res !== exp_pos || got_q[0].ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_pos: out=%h ovf=%b expected %h/1", got_q[0].res, got_q[0].ovf, exp_pos);
            end
            checks++;
            if (got_q[1].res !== exp_neg || got_q[1].ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_neg_sub: out=%h ovf=%b expected %h/1", got_q[1].res, got_q[1].ovf, exp_neg);
            end
            checks++;
            if (got_q[2].res !== 17'h1FFFE || got_q[2].ovf !== 1'b0) begin
                errors++;
                $display("FAIL carry_no_ovf: out=%h ovf=%b expected 1fffe/0", got_q[2].res, got_q[2].ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in     = 16'(i);
            b_in     = 16'(i * 3);
            cin      = 1'b0;
            sub      = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready: beat %0d in_ready=%b expected 1", i, in_ready);
            end
            cyc();
        end
        in_valid = 1'b0;
        wait_results("b2b", 8, 20);
        if (got_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i].res !== 17'(4 * i) || got_q[i].cyc !== got_q[0].cyc + i) begin
                    errors++;
                    $display("FAIL b2b_result: idx %0d out=%h cycle=%0d expected out=%h cycle=%0d",
                             i, got_q[i].res, got_q[i].cyc, 17'(4 * i), got_q[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        got_q.delete();
        stall_seen = 0;
        sent = 0;
        for (int t = 0; t < 40 && (sent < 6 || t <= 10); t++) begin
            out_ready = !(t >= 5 && t <= 9);
            in_valid  = (sent < 6);
            a_in      = 16'(16'h0100 * sent + 16'h0011);
            b_in      = 16'(sent);
            cin       = 1'b0;
            sub       = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 6 || stall_seen == 0) begin
            errors++;
            $display("FAIL bp_stream: sent=%0d stall_cycles=%0d expected 6 sent and a stall", sent, stall_seen);
        end
        wait_results("bp", 6, 30);
        if (got_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_q[i].res !== 17'(16'h0100 * i + 16'h0011 + i)) begin
                    errors++;
                    $display("FAIL bp_order: idx %0d out=%h expected %h",
                             i, got_q[i].res, 17'(16'h0100 * i + 16'h0011 + i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        out_ready = 1'b1;
        send_beat(16'h0010, 16'h0001, 1'b0, 1'b0);
        send_beat(16'h0020, 16'h0001, 1'b0, 1'b0);
        send_beat(16'h0030, 16'h0001, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b out=%h ovf=%b expected 0/0/0", out_valid, out, ovf);
        end
        for (int i = 0; i < 8; i++) cyc();
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_flush: %0d stale results emerged expected 0", got_q.size());
        end
        send_beat(16'h0042, 16'h0001, 1'b0, 1'b0);
        check_latency("midreset", 17'h00043, 1'b0);
        wait_results("midreset", 1, 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_add();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
